// File: rtl/alu_seq.sv
// Sequential arithmetic unit: add/sub in one step, shift-add multiply and
// restoring-division modulo in W iterations each; result held until next start.
module alu_seq #(
    parameter int unsigned W      = 8,
    parameter logic [7:0]  OP_ADD = 8'd130,
    parameter logic [7:0]  OP_SUB = 8'd131,
    parameter logic [7:0]  OP_MUL = 8'd132,
    parameter logic [7:0]  OP_MOD = 8'd133
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [7:0]       op,
    output logic [2*W-1:0]   result,
    output logic             sign,
    output logic             err,
    output logic             valid,
    output logic             busy
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {IDLE, ADDSUB, MUL, DIV, DONE} state_t;

    state_t           state, state_nx;
    logic [W-1:0]     a_r, b_r;
    logic [7:0]       op_r;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [2*W-1:0]   acc, mcand;
    logic [W-1:0]     mplier;
    logic [W-1:0]     rem, dvd;
    logic [W:0]       trial;
    logic [2*W-1:0]   res_r;
    logic             sgn_r;
    logic             err_p;
    logic             busy_nx;
    logic             op_bad;

    assign trial = {rem, dvd[W-1]};

    always_comb begin
        op_bad = !(op == OP_ADD || op == OP_SUB || op == OP_MUL ||
                   (op == OP_MOD && b != '0));
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op == OP_ADD || op == OP_SUB)       state_nx = ADDSUB;
                    else if (op == OP_MUL)                  state_nx = MUL;
                    else if (op == OP_MOD && b != '0)       state_nx = DIV;
                    else                                    state_nx = DONE;
                end
            end
            ADDSUB:  state_nx = DONE;
            MUL:     if (last) state_nx = DONE;
            DIV:     if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx == ADDSUB) || (state_nx == MUL) || (state_nx == DIV);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= '0;
            cnt    <= '0;
            last   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            rem    <= '0;
            dvd    <= '0;
            res_r  <= '0;
            sgn_r  <= 1'b0;
            err_p  <= 1'b0;
            result <= '0;
            sign   <= 1'b0;
            err    <= 1'b0;
            valid  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            valid <= (state == DONE);
            busy  <= busy_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r    <= a;
                        b_r    <= b;
                        op_r   <= op;
                        cnt    <= '0;
                        last   <= 1'b0;
                        acc    <= '0;
                        mcand  <= (2*W)'(a);
                        mplier <= b;
                        rem    <= '0;
                        dvd    <= a;
                        err_p  <= op_bad;
                    end
                end
                ADDSUB: begin
                    if (op_r == OP_ADD) begin
                        res_r <= (2*W)'(a_r) + (2*W)'(b_r);
                        sgn_r <= 1'b0;
                    end else if (a_r >= b_r) begin
                        res_r <= (2*W)'(a_r - b_r);
                        sgn_r <= 1'b0;
                    end else begin
                        res_r <= (2*W)'(b_r - a_r);
                        sgn_r <= 1'b1;
                    end
                end
                MUL: begin
                    // W iterations, then one extra cycle to publish the product
                    if (!last) begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        if (cnt == CW'(W-1)) last <= 1'b1;
                        else                 cnt  <= cnt + 1'b1;
                    end else begin
                        res_r <= acc;
                        sgn_r <= 1'b0;
                    end
                end
                DIV: begin
                    if (!last) begin
                        if (trial >= {1'b0, b_r}) rem <= W'(trial - {1'b0, b_r});
                        else                      rem <= trial[W-1:0];
                        dvd <= dvd << 1;
                        if (cnt == CW'(W-1)) last <= 1'b1;
                        else                 cnt  <= cnt + 1'b1;
                    end else begin
                        res_r <= (2*W)'(rem);
                        sgn_r <= 1'b0;
                    end
                end
                DONE: begin
                    // an error completion leaves the previous result and sign intact
                    err <= err_p;
                    if (!err_p) begin
                        result <= res_r;
                        sign   <= sgn_r;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
